// File: rtl/opcol_collect.sv
// opcol_collect: gathers up to three source operands per warp instruction from the
// register file into per-lane slots, then presents the collected packet downstream.
module opcol_collect #(
    parameter int NUM_LANES = 32,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 6,
    parameter int WARP_W    = 5,
    parameter int SM_W      = 4,
    parameter int PKT_W     = 128
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            disp_valid_i,
    output logic                            disp_ready_o,
    input  logic [SM_W-1:0]                 disp_sm_i,
    input  logic [WARP_W-1:0]               disp_warp_i,
    input  logic [PKT_W-1:0]                disp_pkt_i,
    input  logic [NUM_LANES-1:0]            disp_mask_i,
    input  logic [3*REG_W-1:0]              disp_src_i,
    input  logic [2:0]                      disp_srcv_i,
    output logic                            rf_req_o,
    output logic [WARP_W-1:0]               rf_warp_o,
    output logic [REG_W-1:0]                rf_addr_o,
    input  logic                            rf_gnt_i,
    input  logic                            rf_rvalid_i,
    input  logic [NUM_LANES*DATA_W-1:0]     rf_rdata_i,
    input  logic                            stall_i,
    output logic                            fu_valid_o,
    output logic [SM_W-1:0]                 fu_sm_o,
    output logic [WARP_W-1:0]               fu_warp_o,
    output logic [PKT_W-1:0]                fu_pkt_o,
    output logic [NUM_LANES-1:0]            fu_mask_o,
    output logic [NUM_LANES*3*DATA_W-1:0]   fu_lanes_o
);
    typedef enum logic [1:0] {IDLE, READ, WAIT, ISSUE} state_t;

    state_t                          state_q, state_d;
    logic [SM_W-1:0]                 sm_q, sm_d;
    logic [WARP_W-1:0]               warp_q, warp_d;
    logic [PKT_W-1:0]                pkt_q, pkt_d;
    logic [NUM_LANES-1:0]            mask_q, mask_d;
    logic [3*REG_W-1:0]              src_q, src_d;
    logic [2:0]                      srcv_q, srcv_d;
    logic [1:0]                      sel_q, sel_d;
    logic [NUM_LANES*3*DATA_W-1:0]   lanes_q, lanes_d;
    logic [2:0]                      rem;

    function automatic logic [1:0] first_src(input logic [2:0] v);
        return v[0] ? 2'd0 : v[1] ? 2'd1 : 2'd2;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sm_q    <= '0;
            warp_q  <= '0;
            pkt_q   <= '0;
            mask_q  <= '0;
            src_q   <= '0;
            srcv_q  <= '0;
            sel_q   <= '0;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            sm_q    <= sm_d;
            warp_q  <= warp_d;
            pkt_q   <= pkt_d;
            mask_q  <= mask_d;
            src_q   <= src_d;
            srcv_q  <= srcv_d;
            sel_q   <= sel_d;
            lanes_q <= lanes_d;
        end
    end

    // srcv_q holds the sources still to be read; each capture retires the selected one
    always_comb begin
        state_d = state_q;
        sm_d    = sm_q;
        warp_d  = warp_q;
        pkt_d   = pkt_q;
        mask_d  = mask_q;
        src_d   = src_q;
        srcv_d  = srcv_q;
        sel_d   = sel_q;
        lanes_d = lanes_q;
        rem     = srcv_q & ~(3'b001 << sel_q);
        case (state_q)
            IDLE: if (disp_valid_i) begin
                sm_d    = disp_sm_i;
                warp_d  = disp_warp_i;
                pkt_d   = disp_pkt_i;
                mask_d  = disp_mask_i;
                src_d   = disp_src_i;
                srcv_d  = disp_srcv_i;
                sel_d   = first_src(disp_srcv_i);
                lanes_d = '0;
                state_d = |disp_srcv_i ? READ : ISSUE;
            end
            READ: state_d = rf_gnt_i ? WAIT : READ;
            WAIT: if (rf_rvalid_i) begin
                for (int k = 0; k < NUM_LANES; k++)
                    for (int j = 0; j < 3; j++)
                        if (mask_q[k] && sel_q == 2'(j))
                            lanes_d[(k*3+j)*DATA_W +: DATA_W] = rf_rdata_i[k*DATA_W +: DATA_W];
                srcv_d  = rem;
                sel_d   = first_src(rem);
                state_d = |rem ? READ : ISSUE;
            end
            default: state_d = stall_i ? ISSUE : IDLE;
        endcase
    end

    always_comb begin
        disp_ready_o = state_q == IDLE;
        rf_req_o     = state_q == READ;
        fu_valid_o   = state_q == ISSUE;
        rf_warp_o    = warp_q;
        rf_addr_o    = sel_q == 2'd0 ? src_q[0 +: REG_W] :
                       sel_q == 2'd1 ? src_q[REG_W +: REG_W] : src_q[2*REG_W +: REG_W];
        fu_sm_o      = sm_q;
        fu_warp_o    = warp_q;
        fu_pkt_o     = pkt_q;
        fu_mask_o    = mask_q;
        fu_lanes_o   = lanes_q;
    end
endmodule

// File: tb/tb_opcol_collect.sv
// tb_opcol_collect: table-driven directed checks of operand collection, plus
// hand-written reset-abort and back-to-back sequences.
module tb_opcol_collect;
    localparam int NL = 32, DW = 32, RW = 6, WW = 5, SW = 4, PW = 128;

    logic              clk = 0, reset = 1;
    logic              disp_valid_i = 0, disp_ready_o;
    logic [SW-1:0]     disp_sm_i = '0;
    logic [WW-1:0]     disp_warp_i = '0;
    logic [PW-1:0]     disp_pkt_i = '0;
    logic [NL-1:0]     disp_mask_i = '0;
    logic [3*RW-1:0]   disp_src_i = '0;
    logic [2:0]        disp_srcv_i = '0;
    logic              rf_req_o, rf_gnt_i = 0, rf_rvalid_i = 0;
    logic [WW-1:0]     rf_warp_o;
    logic [RW-1:0]     rf_addr_o;
    logic [NL*DW-1:0]  rf_rdata_i = '0;
    logic              stall_i = 0, fu_valid_o;
    logic [SW-1:0]     fu_sm_o;
    logic [WW-1:0]     fu_warp_o;
    logic [PW-1:0]     fu_pkt_o;
    logic [NL-1:0]     fu_mask_o;
    logic [NL*3*DW-1:0] fu_lanes_o;

    opcol_collect dut (
        .clk(clk), .reset(reset),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_sm_i(disp_sm_i), .disp_warp_i(disp_warp_i), .disp_pkt_i(disp_pkt_i),
        .disp_mask_i(disp_mask_i), .disp_src_i(disp_src_i), .disp_srcv_i(disp_srcv_i),
        .rf_req_o(rf_req_o), .rf_warp_o(rf_warp_o), .rf_addr_o(rf_addr_o),
        .rf_gnt_i(rf_gnt_i), .rf_rvalid_i(rf_rvalid_i), .rf_rdata_i(rf_rdata_i),
        .stall_i(stall_i), .fu_valid_o(fu_valid_o), .fu_sm_o(fu_sm_o),
        .fu_warp_o(fu_warp_o), .fu_pkt_o(fu_pkt_o), .fu_mask_o(fu_mask_o),
        .fu_lanes_o(fu_lanes_o)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // register-file model: lane k of register r reads 0x100*r + k, or all ones when fill is set
    function automatic logic [NL*DW-1:0] rd(input int r, input bit fill);
        logic [NL*DW-1:0] v;
        for (int k = 0; k < NL; k++) v[k*DW +: DW] = fill ? '1 : 32'(32'h100 * r + k);
        return v;
    endfunction

    typedef struct {
        logic [2:0]    srcv;
        logic [3*RW-1:0] src;
        logic [NL-1:0] mask;
        bit            fill;
        int            gdelay;
        int            stall;
        int            lat;
    } vec_t;

    // entered and left at a negedge with the DUT idle
    task automatic run(input vec_t v, input int idx);
        int exp_addr[$];
        int cyc, hold, rd_i, preg, e;
        bit pend;
        logic [NL*3*DW-1:0] snap;
        logic [DW-1:0] ev;
        for (int j = 0; j < 3; j++) if (v.srcv[j]) exp_addr.push_back(int'(v.src[j*RW +: RW]));
        check("ready_idle", 128'(disp_ready_o), 128'(1));
        disp_valid_i = 1;
        disp_sm_i    = SW'(idx + 1);
        disp_warp_i  = WW'(idx * 3 + 2);
        disp_pkt_i   = {4{32'hC0DE0000 + 32'(idx)}};
        disp_mask_i  = v.mask;
        disp_src_i   = v.src;
        disp_srcv_i  = v.srcv;
        @(negedge clk);
        disp_valid_i = 0;
        cyc = 1; hold = 0; rd_i = 0; pend = 0; preg = 0;
        while (!fu_valid_o && cyc < 100) begin
            rf_gnt_i = 0;
            rf_rvalid_i = 0;
            if (pend) begin
                rf_rvalid_i = 1;
                rf_rdata_i  = rd(preg, v.fill);
                pend = 0;
            end else if (rf_req_o) begin
                e = rd_i < exp_addr.size() ? exp_addr[rd_i] : 99;
                check("rf_addr", 128'(rf_addr_o), 128'(e));
                check("rf_warp", 128'(rf_warp_o), 128'(idx * 3 + 2));
                if (rd_i == 0 && hold < v.gdelay) hold++;
                else begin
                    rf_gnt_i = 1;
                    pend = 1;
                    preg = int'(rf_addr_o);
                    rd_i++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rf_gnt_i = 0;
        rf_rvalid_i = 0;
        check("latency", 128'(cyc), 128'(v.lat));
        check("num_reads", 128'(rd_i), 128'(exp_addr.size()));
        check("fu_sm", 128'(fu_sm_o), 128'(idx + 1));
        check("fu_warp", 128'(fu_warp_o), 128'(idx * 3 + 2));
        check("fu_pkt", fu_pkt_o, {4{32'hC0DE0000 + 32'(idx)}});
        check("fu_mask", 128'(fu_mask_o), 128'(v.mask));
        for (int k = 0; k < NL; k++) begin
            logic [3*DW-1:0] el;
            for (int j = 0; j < 3; j++) begin
                ev = v.fill ? '1 : 32'(32'h100 * int'(v.src[j*RW +: RW]) + k);
                el[j*DW +: DW] = (v.srcv[j] && v.mask[k]) ? ev : '0;
            end
            check($sformatf("lane%0d", k), 128'(fu_lanes_o[k*3*DW +: 3*DW]), 128'(el));
        end
        snap = fu_lanes_o;
        for (int s = 0; s < v.stall; s++) begin
            stall_i = 1;
            @(negedge clk);
            check("stall_valid", 128'(fu_valid_o), 128'(1));
            check("stall_ready", 128'(disp_ready_o), 128'(0));
            check("stall_stable", 128'(fu_lanes_o == snap && fu_sm_o == SW'(idx + 1)), 128'(1));
        end
        stall_i = 0;
        @(negedge clk);
        check("consumed_valid", 128'(fu_valid_o), 128'(0));
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{3'b111, {6'd9, 6'd5, 6'd3},   32'hFFFF_FFFF, 0, 0, 0, 7};
        vecs[1] = '{3'b000, {6'd1, 6'd2, 6'd3},   32'hFFFF_FFFF, 0, 0, 0, 1};
        vecs[2] = '{3'b001, {6'd0, 6'd0, 6'd7},   32'h0000_00F0, 1, 0, 0, 3};
        vecs[3] = '{3'b010, {6'd0, 6'd12, 6'd0},  32'hA5A5_0F0F, 0, 5, 0, 8};
        vecs[4] = '{3'b101, {6'd33, 6'd0, 6'd17}, 32'h8000_0001, 0, 0, 3, 5};
        vecs[5] = '{3'b110, {6'd63, 6'd40, 6'd1}, 32'hFFFF_FFFF, 0, 2, 1, 7};
        repeat (2) @(negedge clk);
        reset = 0;
        check("rst_ready", 128'(disp_ready_o), 128'(1));
        check("rst_req", 128'(rf_req_o), 128'(0));
        check("rst_valid", 128'(fu_valid_o), 128'(0));
        check("rst_pkt", fu_pkt_o, 128'(0));
        for (int i = 0; i < 6; i++) begin
            run(vecs[i], i);
            if (i == 0) check("lane2_triple", 128'(fu_lanes_o[2*96 +: 96]), 128'({32'h902, 32'h502, 32'h302}));
            if (i == 2) begin
                check("lane4_slot0", 128'(fu_lanes_o[4*96 +: 32]), 128'(32'hFFFF_FFFF));
                check("lane3_zero", 128'(fu_lanes_o[3*96 +: 96]), 128'(0));
                check("lane8_zero", 128'(fu_lanes_o[8*96 +: 96]), 128'(0));
            end
        end
        // reset lands while waiting for read data; the late data must be dropped
        disp_valid_i = 1;
        disp_sm_i = 4'd9; disp_warp_i = 5'd21; disp_pkt_i = {4{32'hDEAD_BEEF}};
        disp_mask_i = '1; disp_src_i = {6'd0, 6'd0, 6'd7}; disp_srcv_i = 3'b001;
        @(negedge clk);
        disp_valid_i = 0;
        check("abort_req", 128'(rf_req_o), 128'(1));
        rf_gnt_i = 1;
        @(negedge clk);
        rf_gnt_i = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        rf_rvalid_i = 1;
        rf_rdata_i = rd(7, 1);
        @(negedge clk);
        rf_rvalid_i = 0;
        check("abort_ready", 128'(disp_ready_o), 128'(1));
        check("abort_req_low", 128'(rf_req_o), 128'(0));
        check("abort_valid", 128'(fu_valid_o), 128'(0));
        check("abort_lanes", 128'(fu_lanes_o == '0), 128'(1));
        check("abort_pkt", fu_pkt_o, 128'(0));
        check("abort_fields", 128'({fu_sm_o, fu_warp_o, fu_mask_o, rf_addr_o}), 128'(0));
        run(vecs[4], 4);
        run(vecs[0], 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/opcol_collect.md
OPCOL_COLLECT -- requirements
Module: opcol_collect

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_LANES, 32, SIMD lanes per warp.
- DATA_W, 32, operand width per lane.
- REG_W, 6, register index width.
- WARP_W, 5, warp id width.
- SM_W, 4, SM id width.
- PKT_W, 128, opaque decoded-instruction packet width.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- disp_valid_i, in, 1, dispatch offers an instruction.
- disp_ready_o, out, 1, block accepts a dispatch.
- disp_sm_i, in, SM_W, SM id.
- disp_warp_i, in, WARP_W, warp id.
- disp_pkt_i, in, PKT_W, decoded packet.
- disp_mask_i, in, NUM_LANES, active-lane mask.
- disp_src_i, in, 3*REG_W, source register indices; src j at [j*REG_W +: REG_W].
- disp_srcv_i, in, 3, per-source valid.
- rf_req_o, out, 1, register-file read request.
- rf_warp_o, out, WARP_W, warp being read.
- rf_addr_o, out, REG_W, register being read.
- rf_gnt_i, in, 1, request accepted this cycle.
- rf_rvalid_i, in, 1, read data valid.
- rf_rdata_i, in, NUM_LANES*DATA_W, lane k at [k*DATA_W +: DATA_W].
- stall_i, in, 1, downstream pipeline register holding.
- fu_valid_o, out, 1, collected packet valid.
- fu_sm_o, out, SM_W, captured SM id.
- fu_warp_o, out, WARP_W, captured warp id.
- fu_pkt_o, out, PKT_W, captured packet.
- fu_mask_o, out, NUM_LANES, captured mask.
- fu_lanes_o, out, NUM_LANES*3*DATA_W, lane k at [k*3*DATA_W +: 3*DATA_W]; operand j within lane at [j*DATA_W +: DATA_W].

Function
REQ-003 States: IDLE, READ, WAIT, ISSUE; 2-bit encoded.
REQ-004 disp_ready_o SHALL be 1 only in IDLE; a dispatch is accepted when disp_valid_i and disp_ready_o are both 1.
REQ-005 On accept, the block SHALL capture sm, warp, pkt, mask, src, and srcv, and SHALL clear all operand slots to zero.
REQ-006 After accept, the block SHALL go to READ with the lowest-index valid source selected, or to ISSUE if disp_srcv_i = 3'b000.
REQ-007 In READ, rf_req_o SHALL be 1, with rf_warp_o set to the captured warp and rf_addr_o set to the selected source index; rf_req_o SHALL be 0 in every other state.
REQ-008 In READ, rf_gnt_i = 1 SHALL move the block to WAIT; while rf_gnt_i = 0 the block SHALL stay in READ with the request held stable.
REQ-009 In WAIT, on rf_rvalid_i = 1, the block SHALL write rf_rdata_i into slot j of every lane whose captured mask bit is 1; masked-off lanes SHALL stay zero.
REQ-010 After that capture, the block SHALL go to READ for the next higher valid source, or to ISSUE if none remain.
REQ-011 rf_rvalid_i SHALL be ignored outside WAIT.
REQ-012 In ISSUE, fu_valid_o SHALL be 1; fu_valid_o SHALL be 0 in every other state.
REQ-013 In ISSUE with stall_i = 0, the packet SHALL be consumed that cycle and the block SHALL go to IDLE.
REQ-014 In ISSUE with stall_i = 1, the block SHALL stay in ISSUE with all fu_* outputs unchanged.
REQ-015 fu_* outputs SHALL reflect the captured registers in every state; their values are meaningful only while fu_valid_o = 1.
REQ-016 Latency: with no stalls and grant/rvalid each arriving in the earliest possible cycle, fu_valid_o SHALL rise N*2+1 cycles after the accept edge, where N is the number of valid sources.
REQ-017 stall_i SHALL NOT affect the READ or WAIT states.
REQ-018 Back-to-back operation: the earliest next accept SHALL be the cycle after ISSUE is consumed, with no dead cycle beyond IDLE.

Reset
REQ-019 When reset = 1 at a clock edge, state SHALL become IDLE, and every output register, captured field, and operand slot SHALL become 0.
REQ-020 Reset SHALL take priority over all handshakes, including mid-READ, mid-WAIT, and mid-ISSUE with stall_i = 1.
REQ-021 An rf_rvalid_i arriving after a reset-aborted read SHALL be discarded.
REQ-022 After reset: disp_ready_o = 1, rf_req_o = 0, fu_valid_o = 0.

Verification
REQ-023 Dispatch srcv = 3'b111, src = {R9, R5, R3}, mask = all ones; rf grants immediately and returns lane k = 0x100*reg + k -> reads issued to R3, R5, R9 in order; fu_valid_o rises 7 cycles after accept; lane 2 = {0x902, 0x502, 0x302}.
REQ-024 Dispatch srcv = 3'b000 -> fu_valid_o = 1 one cycle after accept; rf_req_o never asserts; all operand slots 0.
REQ-025 Mask = 0x0000_00F0, single source src0, rdata all 0xFFFF_FFFF -> lanes 4-7 slot 0 = 0xFFFF_FFFF; all other lanes 0.
REQ-026 rf_gnt_i held low 5 cycles in READ -> rf_req_o and rf_addr_o stable for those 5 cycles; completion is delayed by exactly 5 cycles.
REQ-027 ISSUE with stall_i high 3 cycles -> fu_* outputs bit-identical for 4 cycles; disp_ready_o low until the cycle after stall_i falls.
REQ-028 Reset asserted in WAIT, with rf_rvalid_i high on the following cycle -> IDLE, all outputs 0, late data not captured.
